id_stage_v2: RTL and testbench

Parametrised next-generation MIPS instruction-decode stage: register bank with width and depth parameters, a write-to-read bypass, load-use and branch hazard detection with stall and bubble insertion, branch and jump resolution in ID, and an owned ID/EX pipeline register with flush, enable and a sticky halt. It sits between the IF/ID register and EX. It replaces the combinational decode and mux-control path, so EX sees only registered control and operands.

---
 rtl/id_stage_v2.sv | 269 ++++++++++++++++++++++++++
 tb/tb_id_stage_v2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_v2.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_v2
// Purpose  : MIPS instruction-decode stage. Contains the register bank with
//            write-to-read bypass, decode, load-use and branch/JR hazard
//            detection, branch/jump resolution, and the ID/EX pipeline
//            register with flush, enable and a sticky halt.
// Ports    : i_clock/i_reset (sync, active-low), i_enable, i_flush,
//            IF/ID inputs (i_instruccion, i_pc_plus4), WB write port
//            (i_regwrite, i_rt_rd, i_writedata), EX/MEM load info
//            (i_mem_memread, i_mem_dst), debug read (i_debug_addr ->
//            o_reg_debug), combinational o_stall/o_pc_redirect/o_pc_target,
//            registered o_ex_* bundle and o_halt.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_v2 #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_REG       = 31
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_flush,
  input  logic [31:0]               i_instruccion,
  input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
  input  logic                      i_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] i_rt_rd,
  input  logic [DATA_WIDTH-1:0]     i_writedata,
  input  logic                      i_mem_memread,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_dst,
  input  logic [REG_ADDR_WIDTH-1:0] i_debug_addr,
  output logic                      o_stall,
  output logic                      o_pc_redirect,
  output logic [DATA_WIDTH-1:0]     o_pc_target,
  output logic [DATA_WIDTH-1:0]     o_ex_regA,
  output logic [DATA_WIDTH-1:0]     o_ex_regB,
  output logic [DATA_WIDTH-1:0]     o_ex_imm,
  output logic [DATA_WIDTH-1:0]     o_ex_link,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] o_ex_dst,
  output logic [5:0]                o_ex_opcode,
  output logic [5:0]                o_ex_funct,
  output logic                      o_ex_regwrite,
  output logic                      o_ex_memread,
  output logic                      o_ex_memwrite,
  output logic                      o_ex_memtoreg,
  output logic                      o_ex_alusrc,
  output logic                      o_ex_link_sel,
  output logic                      o_halt,
  output logic [DATA_WIDTH-1:0]     o_reg_debug
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_halt  = 6'h3F;
  localparam logic [5:0] c_fn_jr    = 6'h08;
  localparam logic [5:0] c_fn_jalr  = 6'h09;

  localparam logic [REG_ADDR_WIDTH-1:0] c_link_reg = REG_ADDR_WIDTH'(LINK_REG);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     reg_a;
    logic [DATA_WIDTH-1:0]     reg_b;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     link;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] dst;
    logic [5:0]                opcode;
    logic [5:0]                funct;
    logic                      regwrite;
    logic                      memread;
    logic                      memwrite;
    logic                      memtoreg;
    logic                      alusrc;
    logic                      link_sel;
  } idex_t;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  idex_t                 ex_q, ex_d, dec;
  logic                  halt_q, halt_d;

  // Register read with same-cycle WB bypass; index 0 is hardwired to zero.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [REG_ADDR_WIDTH-1:0] idx);
    if (idx == '0)                         return '0;
    else if (i_regwrite && i_rt_rd == idx) return i_writedata;
    else                                   return regs_q[idx];
  endfunction

  // A branch/JR source is not yet available if an older instruction in EX
  // (ALU result) or MEM (load data) is still producing it.
  function automatic logic ctrl_src_busy(input logic [REG_ADDR_WIDTH-1:0] idx);
    return (idx != '0) &&
           ((ex_q.regwrite && ex_q.dst == idx) || (i_mem_memread && i_mem_dst == idx));
  endfunction

  logic [5:0]                w_opcode, w_funct;
  logic [REG_ADDR_WIDTH-1:0] w_rs, w_rt, w_rd;
  logic [DATA_WIDTH-1:0]     w_imm_ext, w_br_target, w_j_target;
  logic                      w_valid, w_uses_rs, w_uses_rt, w_is_branch, w_is_jr, w_is_halt;
  logic                      w_take;
  logic [DATA_WIDTH-1:0]     w_target;
  logic                      w_load_use, w_ctrl_haz, w_stall;

  assign w_opcode    = i_instruccion[31:26];
  assign w_funct     = i_instruccion[5:0];
  assign w_rs        = i_instruccion[21 +: REG_ADDR_WIDTH];
  assign w_rt        = i_instruccion[16 +: REG_ADDR_WIDTH];
  assign w_rd        = i_instruccion[11 +: REG_ADDR_WIDTH];
  assign w_imm_ext   = {{(DATA_WIDTH-16){i_instruccion[15]}}, i_instruccion[15:0]};
  assign w_br_target = i_pc_plus4 + (w_imm_ext << 2);
  assign w_j_target  = {i_pc_plus4[DATA_WIDTH-1:28], i_instruccion[25:0], 2'b00};

  always_comb begin
    dec          = '0;
    dec.reg_a    = read_reg(w_rs);
    dec.reg_b    = read_reg(w_rt);
    dec.imm      = w_imm_ext;
    dec.link     = i_pc_plus4;
    dec.rs       = w_rs;
    dec.rt       = w_rt;
    dec.opcode   = w_opcode;
    dec.funct    = w_funct;
    w_valid      = 1'b0;
    w_uses_rs    = 1'b0;
    w_uses_rt    = 1'b0;
    w_is_branch  = 1'b0;
    w_is_jr      = 1'b0;
    w_is_halt    = 1'b0;
    w_take       = 1'b0;
    w_target     = '0;
    case (w_opcode)
      c_op_rtype: begin
        w_valid   = 1'b1;
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
        if (w_funct == c_fn_jr) begin
          w_is_jr  = 1'b1;
          w_take   = 1'b1;
          w_target = dec.reg_a;
        end else begin
          dec.dst      = w_rd;
          dec.regwrite = 1'b1;
          if (w_funct == c_fn_jalr) begin
            w_is_jr      = 1'b1;
            w_take       = 1'b1;
            w_target     = dec.reg_a;
            dec.link_sel = 1'b1;
          end
        end
      end
      c_op_lw: begin
        w_valid      = 1'b1;
        w_uses_rs    = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.dst      = w_rt;
      end
      c_op_sw: begin
        w_valid      = 1'b1;
        w_uses_rs    = 1'b1;
        w_uses_rt    = 1'b1;
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      c_op_addi: begin
        w_valid      = 1'b1;
        w_uses_rs    = 1'b1;
        dec.alusrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.dst      = w_rt;
      end
      c_op_beq, c_op_bne: begin
        w_valid     = 1'b1;
        w_uses_rs   = 1'b1;
        w_uses_rt   = 1'b1;
        w_is_branch = 1'b1;
        w_take      = (dec.reg_a == dec.reg_b) ^ (w_opcode == c_op_bne);
        w_target    = w_br_target;
      end
      c_op_j: begin
        w_valid  = 1'b1;
        w_take   = 1'b1;
        w_target = w_j_target;
      end
      c_op_jal: begin
        w_valid      = 1'b1;
        w_take       = 1'b1;
        w_target     = w_j_target;
        dec.dst      = c_link_reg;
        dec.regwrite = 1'b1;
        dec.link_sel = 1'b1;
      end
      c_op_halt: begin
        w_valid   = 1'b1;
        w_is_halt = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_load_use = ex_q.memread && (ex_q.dst != '0) &&
                      ((w_uses_rs && ex_q.dst == w_rs) || (w_uses_rt && ex_q.dst == w_rt));
  assign w_ctrl_haz = (w_is_branch && (ctrl_src_busy(w_rs) || ctrl_src_busy(w_rt))) ||
                      (w_is_jr && ctrl_src_busy(w_rs));
  assign w_stall    = w_load_use || w_ctrl_haz || halt_q;

  always_comb begin
    regs_d = regs_q;
    ex_d   = ex_q;
    halt_d = halt_q;
    if (i_enable) begin
      if (i_regwrite && i_rt_rd != '0) regs_d[i_rt_rd] = i_writedata;
      // Flush, stall, halt and unrecognised opcodes all load a bubble.
      if (i_flush || w_stall || !w_valid) ex_d = '0;
      else                                ex_d = dec;
      if (w_is_halt && !w_stall && !i_flush) halt_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      ex_q   <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      ex_q   <= ex_d;
      halt_q <= halt_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign o_stall       = w_stall;
  assign o_pc_redirect = w_take && !w_stall;
  assign o_pc_target   = w_target;
  assign o_reg_debug   = read_reg(i_debug_addr);
  assign o_halt        = halt_q;

  assign o_ex_regA     = ex_q.reg_a;
  assign o_ex_regB     = ex_q.reg_b;
  assign o_ex_imm      = ex_q.imm;
  assign o_ex_link     = ex_q.link;
  assign o_ex_rs       = ex_q.rs;
  assign o_ex_rt       = ex_q.rt;
  assign o_ex_dst      = ex_q.dst;
  assign o_ex_opcode   = ex_q.opcode;
  assign o_ex_funct    = ex_q.funct;
  assign o_ex_regwrite = ex_q.regwrite;
  assign o_ex_memread  = ex_q.memread;
  assign o_ex_memwrite = ex_q.memwrite;
  assign o_ex_memtoreg = ex_q.memtoreg;
  assign o_ex_alusrc   = ex_q.alusrc;
  assign o_ex_link_sel = ex_q.link_sel;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_v2.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_id_stage_v2
// Purpose  : Directed-vector bench for id_stage_v2. The driver pushes the
//            expected ID/EX contents for every edge into a queue; a monitor
//            pops and compares after each edge. Combinational outputs are
//            compared by the driver in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_v2;

  logic        i_clock = 1'b0;
  logic        i_reset, i_enable, i_flush;
  logic [31:0] i_instruccion, i_pc_plus4, i_writedata;
  logic        i_regwrite, i_mem_memread;
  logic [4:0]  i_rt_rd, i_mem_dst, i_debug_addr;
  logic        o_stall, o_pc_redirect, o_halt;
  logic [31:0] o_pc_target, o_ex_regA, o_ex_regB, o_ex_imm, o_ex_link, o_reg_debug;
  logic [4:0]  o_ex_rs, o_ex_rt, o_ex_dst;
  logic [5:0]  o_ex_opcode, o_ex_funct;
  logic        o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_memtoreg, o_ex_alusrc, o_ex_link_sel;

  always #5 i_clock = ~i_clock;

  id_stage_v2 dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
    .i_instruccion(i_instruccion), .i_pc_plus4(i_pc_plus4),
    .i_regwrite(i_regwrite), .i_rt_rd(i_rt_rd), .i_writedata(i_writedata),
    .i_mem_memread(i_mem_memread), .i_mem_dst(i_mem_dst), .i_debug_addr(i_debug_addr),
    .o_stall(o_stall), .o_pc_redirect(o_pc_redirect), .o_pc_target(o_pc_target),
    .o_ex_regA(o_ex_regA), .o_ex_regB(o_ex_regB), .o_ex_imm(o_ex_imm), .o_ex_link(o_ex_link),
    .o_ex_rs(o_ex_rs), .o_ex_rt(o_ex_rt), .o_ex_dst(o_ex_dst),
    .o_ex_opcode(o_ex_opcode), .o_ex_funct(o_ex_funct),
    .o_ex_regwrite(o_ex_regwrite), .o_ex_memread(o_ex_memread), .o_ex_memwrite(o_ex_memwrite),
    .o_ex_memtoreg(o_ex_memtoreg), .o_ex_alusrc(o_ex_alusrc), .o_ex_link_sel(o_ex_link_sel),
    .o_halt(o_halt), .o_reg_debug(o_reg_debug)
  );

  typedef struct packed {
    logic [31:0] a, b, imm, link;
    logic [4:0]  rs, rt, dst;
    logic [5:0]  op, fn;
    logic [5:0]  ctl;   // {regwrite, memread, memwrite, memtoreg, alusrc, link_sel}
    logic        halt;
  } pay_t;

  localparam logic [5:0]  CTL_ALUI = 6'b100010;
  localparam logic [5:0]  CTL_LW   = 6'b110110;
  localparam logic [5:0]  CTL_R    = 6'b100000;
  localparam logic [5:0]  CTL_JAL  = 6'b100001;
  localparam logic [31:0] INS_BUB  = 32'hF800_0000;  // opcode 0x3E: undefined
  localparam logic [31:0] INS_HALT = 32'hFC00_0000;
  localparam pay_t        BUB      = '0;

  int   total = 0;
  int   bad   = 0;
  pay_t exp_q[$];
  bit   chk_q[$];
  pay_t act;

  assign act = '{a: o_ex_regA, b: o_ex_regB, imm: o_ex_imm, link: o_ex_link,
                 rs: o_ex_rs, rt: o_ex_rt, dst: o_ex_dst, op: o_ex_opcode, fn: o_ex_funct,
                 ctl: {o_ex_regwrite, o_ex_memread, o_ex_memwrite, o_ex_memtoreg, o_ex_alusrc, o_ex_link_sel},
                 halt: o_halt};

  function automatic pay_t ex(input logic [31:0] a, b, imm, link, input logic [4:0] rs, rt, dst,
                              input logic [5:0] op, fn, ctl, input logic halt);
    pay_t p;
    p = '{a: a, b: b, imm: imm, link: link, rs: rs, rt: rt, dst: dst, op: op, fn: fn, ctl: ctl, halt: halt};
    return p;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
    return {op, t};
  endfunction

  // Monitor: one expected ID/EX entry per edge, compared 1 ns after the edge.
  initial begin
    pay_t e;
    bit   c;
    int   n;
    n = 0;
    forever begin
      @(posedge i_clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = chk_q.pop_front();
        n++;
        if (c) begin
          total++;
          if (act !== e) begin
            bad++;
            $display("FAIL idex_edge%0d got=%h want=%h", n, act, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Queue the expected ID/EX state for the coming edge, then cross it.
  task automatic cycle(input bit c, input pay_t e);
    exp_q.push_back(e);
    chk_q.push_back(c);
    @(posedge i_clock);
    #2;
  endtask

  initial begin
    i_reset = 1'b0; i_enable = 1'b1; i_flush = 1'b0;
    i_instruccion = INS_BUB; i_pc_plus4 = '0;
    i_regwrite = 1'b0; i_rt_rd = '0; i_writedata = '0;
    i_mem_memread = 1'b0; i_mem_dst = '0; i_debug_addr = 5'd5;

    // Reset for two cycles
    cycle(1, BUB);
    cycle(1, BUB);
    #1;
    chk("reset_debug_r5", o_reg_debug, 32'h0);
    chk("reset_stall", {31'd0, o_stall}, 32'h0);
    i_reset = 1'b1;

    // Writes to r0 are dropped, bypass visible on the debug port, r1 = r2 = 7
    i_regwrite = 1'b1; i_rt_rd = 5'd0; i_writedata = 32'hDEAD; i_debug_addr = 5'd0;
    #1 chk("r0_reads_zero", o_reg_debug, 32'h0);
    cycle(1, BUB);
    i_rt_rd = 5'd1; i_writedata = 32'd7; i_debug_addr = 5'd1;
    #1 chk("debug_bypass_r1", o_reg_debug, 32'd7);
    cycle(1, BUB);
    i_rt_rd = 5'd2; i_writedata = 32'd7;
    #1 chk("debug_stored_r1", o_reg_debug, 32'd7);
    cycle(1, BUB);

    // ADDI r4, r3, -2 with r3 = 0xA5 arriving from WB this cycle
    i_rt_rd = 5'd3; i_writedata = 32'hA5; i_debug_addr = 5'd3;
    i_instruccion = enc_i(6'h08, 5'd3, 5'd4, 16'hFFFE); i_pc_plus4 = 32'h20;
    #1 chk("addi_stall", {31'd0, o_stall}, 32'h0);
    cycle(1, ex(32'hA5, 0, 32'hFFFF_FFFE, 32'h20, 5'd3, 5'd4, 5'd4, 6'h08, 6'h3E, CTL_ALUI, 1'b0));

    // Enable low: ID/EX holds ADDI and the WB write to r6 is dropped
    i_enable = 1'b0; i_rt_rd = 5'd6; i_writedata = 32'h55; i_debug_addr = 5'd6;
    i_instruccion = enc_r(5'd1, 5'd2, 5'd5, 6'h20); i_pc_plus4 = 32'h24;
    #1 chk("debug_bypass_r6", o_reg_debug, 32'h55);
    cycle(1, ex(32'hA5, 0, 32'hFFFF_FFFE, 32'h20, 5'd3, 5'd4, 5'd4, 6'h08, 6'h3E, CTL_ALUI, 1'b0));

    // LW r2, 0(r1)
    i_enable = 1'b1; i_regwrite = 1'b0;
    i_instruccion = enc_i(6'h23, 5'd1, 5'd2, 16'h0);
    #1 chk("r6_not_written", o_reg_debug, 32'h0);
    cycle(1, ex(32'd7, 32'd7, 0, 32'h24, 5'd1, 5'd2, 5'd2, 6'h23, 6'h00, CTL_LW, 1'b0));

    // ADD r5, r2, r2: one load-use stall, then issue
    i_instruccion = enc_r(5'd2, 5'd2, 5'd5, 6'h20); i_pc_plus4 = 32'h28;
    #1 chk("loaduse_stall", {31'd0, o_stall}, 32'h1);
    cycle(1, BUB);
    #1 chk("loaduse_clear", {31'd0, o_stall}, 32'h0);
    cycle(1, ex(32'd7, 32'd7, 32'h2820, 32'h28, 5'd2, 5'd2, 5'd5, 6'h00, 6'h20, CTL_R, 1'b0));

    // BEQ r1, r2, 3 taken; BNE same operands not taken
    i_instruccion = enc_i(6'h04, 5'd1, 5'd2, 16'd3); i_pc_plus4 = 32'h100;
    #1 chk("beq_redirect", {31'd0, o_pc_redirect}, 32'h1);
    chk("beq_target", o_pc_target, 32'h10C);
    cycle(1, ex(32'd7, 32'd7, 32'd3, 32'h100, 5'd1, 5'd2, 5'd0, 6'h04, 6'h03, 6'b0, 1'b0));
    i_instruccion = enc_i(6'h05, 5'd1, 5'd2, 16'd3);
    #1 chk("bne_redirect", {31'd0, o_pc_redirect}, 32'h0);
    cycle(1, ex(32'd7, 32'd7, 32'd3, 32'h100, 5'd1, 5'd2, 5'd0, 6'h05, 6'h03, 6'b0, 1'b0));

    // ALU producer in EX feeding a branch: one stall, then resolve backwards
    i_instruccion = enc_i(6'h08, 5'd0, 5'd7, 16'd5); i_pc_plus4 = 32'h200;
    cycle(1, ex(0, 0, 32'd5, 32'h200, 5'd0, 5'd7, 5'd7, 6'h08, 6'h05, CTL_ALUI, 1'b0));
    i_instruccion = enc_i(6'h04, 5'd7, 5'd0, 16'hFFFF); i_pc_plus4 = 32'h204;
    #1 chk("brhaz_ex_stall", {30'd0, o_stall, o_pc_redirect}, 32'h2);
    cycle(1, BUB);
    #1 chk("brhaz_ex_clear", {30'd0, o_stall, o_pc_redirect}, 32'h1);
    chk("beq_back_target", o_pc_target, 32'h200);
    cycle(1, ex(0, 0, 32'hFFFF_FFFF, 32'h204, 5'd7, 5'd0, 5'd0, 6'h04, 6'h3F, 6'b0, 1'b0));

    // Load in MEM producing a branch source
    i_mem_memread = 1'b1; i_mem_dst = 5'd1;
    i_instruccion = enc_i(6'h04, 5'd1, 5'd2, 16'd3); i_pc_plus4 = 32'h100;
    #1 chk("brhaz_mem_stall", {30'd0, o_stall, o_pc_redirect}, 32'h2);
    cycle(1, BUB);
    i_mem_memread = 1'b0; i_mem_dst = 5'd0;

    // JAL
    i_instruccion = enc_j(6'h03, 26'h10); i_pc_plus4 = 32'h40;
    #1 chk("jal_target", o_pc_target, 32'h40);
    chk("jal_redirect", {31'd0, o_pc_redirect}, 32'h1);
    cycle(1, ex(0, 0, 32'h10, 32'h40, 5'd0, 5'd0, 5'd31, 6'h03, 6'h10, CTL_JAL, 1'b0));

    // Flush overrides a valid decode
    i_flush = 1'b1; i_instruccion = enc_i(6'h08, 5'd0, 5'd7, 16'd5);
    cycle(1, BUB);
    i_flush = 1'b0;

    // HALT, then enable low for two cycles, then a branch while halted
    i_instruccion = INS_HALT; i_pc_plus4 = 32'h44;
    #1 chk("halt_no_stall", {31'd0, o_stall}, 32'h0);
    cycle(0, BUB);
    chk("halt_set", {31'd0, o_halt}, 32'h1);
    i_enable = 1'b0;
    i_instruccion = enc_i(6'h04, 5'd1, 5'd2, 16'd3); i_pc_plus4 = 32'h100;
    #1 chk("halted_stall_redirect", {30'd0, o_stall, o_pc_redirect}, 32'h2);
    cycle(0, BUB);
    cycle(0, BUB);
    chk("halt_sticky", {31'd0, o_halt}, 32'h1);
    i_enable = 1'b1;
    #1 chk("halted_beq_redirect", {31'd0, o_pc_redirect}, 32'h0);
    cycle(1, ex(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 6'h00, 6'h00, 6'b0, 1'b1));

    // Reset clears halt and the register bank
    i_reset = 1'b0;
    cycle(1, BUB);
    i_reset = 1'b1; i_instruccion = INS_BUB; i_debug_addr = 5'd1;
    #1 chk("post_reset_r1", o_reg_debug, 32'h0);
    chk("post_reset_stall", {31'd0, o_stall}, 32'h0);
    cycle(1, BUB);

    @(posedge i_clock);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
